vad_gate: RTL and testbench

- Voice activity detector that produces the VAD request consumed by the pipeline controller's `vad_i` input. It is the initiator side of the VAD/enable handshake.
- Generates the PDM microphone clock while armed and samples the 1-bit PDM stream.
- Measures pulse-density change between consecutive fixed-length windows.
- Asserts a one-cycle `vad_o` pulse after a programmable number of consecutive windows exceed a runtime threshold.
- Sits beside the controller; disarmed via `en_i`, driven by the controller-side idle indication, whenever the pipeline is on or in timeout.

---
 rtl/vad_gate_if.sv | 22 ++
 rtl/vad_gate.sv | 120 ++++++++++++
 tb/tb_vad_gate.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vad_gate_if.sv
// Arm/PDM/trigger signal bundle between the VAD gate and its controller side.
// master = controller/bench side, slave = vad_gate.
interface vad_gate_if #(
  parameter int unsigned CNT_BW = 9
);
  logic              en_i;
  logic              pdm_data_i;
  logic [CNT_BW-1:0] threshold_i;
  logic              pdm_clk_o;
  logic              sample_o;
  logic              vad_o;

  modport master (
    output en_i, pdm_data_i, threshold_i,
    input  pdm_clk_o, sample_o, vad_o
  );

  modport slave (
    input  en_i, pdm_data_i, threshold_i,
    output pdm_clk_o, sample_o, vad_o
  );
endinterface

// File: rtl/vad_gate.sv
// Voice activity detector: drives the PDM mic clock, counts pulse density per window
// and pulses vad_o after TRIG_WINDOWS consecutive large window-to-window changes.
module vad_gate #(
  parameter int unsigned PDM_DIV      = 4,
  parameter int unsigned WINDOW_LEN   = 256,
  parameter int unsigned TRIG_WINDOWS = 3
) (
  input logic       clk_i,
  input logic       rst_n_i,
  vad_gate_if.slave bus
);
  localparam int unsigned CNT_BW = $clog2(WINDOW_LEN + 1);
  localparam int unsigned DIV_W  = (PDM_DIV > 1) ? $clog2(PDM_DIV) : 1;
  localparam int unsigned HIT_W  = $clog2(TRIG_WINDOWS + 1);

  logic [DIV_W-1:0]  div_q, div_d;
  logic              pdm_clk_q, pdm_clk_d;
  logic              sample_q, sample_d;
  logic              vad_q, vad_d;
  logic [CNT_BW-1:0] smp_cnt_q, smp_cnt_d;
  logic [CNT_BW-1:0] ones_cur_q, ones_cur_d;
  logic [CNT_BW-1:0] ones_prev_q, ones_prev_d;
  logic              prev_valid_q, prev_valid_d;
  logic [HIT_W-1:0]  hit_q, hit_d;

  logic              wrap_c;
  logic              strobe_c;
  logic              last_c;
  logic [CNT_BW-1:0] ones_fin_c;
  logic [CNT_BW-1:0] metric_c;
  logic [HIT_W-1:0]  hit_inc_c;

  // Divider wrap, capture strobe (wrap during the high phase) and window arithmetic
  always_comb begin
    wrap_c     = (div_q == DIV_W'(PDM_DIV - 1));
    strobe_c   = wrap_c & pdm_clk_q;
    last_c     = strobe_c & (smp_cnt_q == CNT_BW'(WINDOW_LEN - 1));
    ones_fin_c = ones_cur_q + CNT_BW'(bus.pdm_data_i);
    metric_c   = (ones_fin_c >= ones_prev_q) ? (ones_fin_c - ones_prev_q)
                                             : (ones_prev_q - ones_fin_c);
    hit_inc_c  = hit_q + HIT_W'(1);
  end

  always_comb begin
    div_d        = wrap_c ? '0 : (div_q + DIV_W'(1));
    pdm_clk_d    = pdm_clk_q ^ wrap_c;
    sample_d     = strobe_c;
    vad_d        = 1'b0;
    smp_cnt_d    = smp_cnt_q;
    ones_cur_d   = ones_cur_q;
    ones_prev_d  = ones_prev_q;
    prev_valid_d = prev_valid_q;
    hit_d        = hit_q;

    if (last_c) begin
      smp_cnt_d    = '0;
      ones_cur_d   = '0;
      ones_prev_d  = ones_fin_c;
      prev_valid_d = 1'b1;
      // First window after arming only seeds the reference count
      if (prev_valid_q) begin
        if (metric_c > bus.threshold_i) begin
          if (hit_inc_c == HIT_W'(TRIG_WINDOWS)) begin
            vad_d = 1'b1;
            hit_d = '0;
          end else begin
            hit_d = hit_inc_c;
          end
        end else begin
          hit_d = '0;
        end
      end
    end else if (strobe_c) begin
      smp_cnt_d  = smp_cnt_q + CNT_BW'(1);
      ones_cur_d = ones_fin_c;
    end

    // Disarm overrides everything, including a coincident window end
    if (!bus.en_i) begin
      div_d        = '0;
      pdm_clk_d    = 1'b0;
      sample_d     = 1'b0;
      vad_d        = 1'b0;
      smp_cnt_d    = '0;
      ones_cur_d   = '0;
      ones_prev_d  = '0;
      prev_valid_d = 1'b0;
      hit_d        = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      div_q        <= '0;
      pdm_clk_q    <= 1'b0;
      sample_q     <= 1'b0;
      vad_q        <= 1'b0;
      smp_cnt_q    <= '0;
      ones_cur_q   <= '0;
      ones_prev_q  <= '0;
      prev_valid_q <= 1'b0;
      hit_q        <= '0;
    end else begin
      div_q        <= div_d;
      pdm_clk_q    <= pdm_clk_d;
      sample_q     <= sample_d;
      vad_q        <= vad_d;
      smp_cnt_q    <= smp_cnt_d;
      ones_cur_q   <= ones_cur_d;
      ones_prev_q  <= ones_prev_d;
      prev_valid_q <= prev_valid_d;
      hit_q        <= hit_d;
    end
  end

  assign bus.pdm_clk_o = pdm_clk_q;
  assign bus.sample_o  = sample_q;
  assign bus.vad_o     = vad_q;

endmodule

// File: tb/tb_vad_gate.sv
// Randomised scoreboard bench for vad_gate: per-sample expected vad bits are queued
// by the stimulus and popped by an independent monitor on every sample_o strobe.
module tb_vad_gate;
  localparam int unsigned PDM_DIV = 2;
  localparam int unsigned WIN     = 16;
  localparam int unsigned TRIG    = 2;
  localparam int unsigned CNT_BW  = $clog2(WIN + 1);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vad_gate_if #(.CNT_BW(CNT_BW)) bus ();

  vad_gate #(
    .PDM_DIV     (PDM_DIV),
    .WINDOW_LEN  (WIN),
    .TRIG_WINDOWS(TRIG)
  ) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;
  bit exp_q[$];
  bit mon_on = 1'b0;
  int vad_seen = 0;
  int win_hist[$];
  int streak = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic fatal_timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting on DUT (t=%0t)", name, $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "aborting run");
  endtask

  // Reference: a window qualifies when its ones count differs from the previous
  // window's by more than thr; vad fires on every TRIG-th qualifying window in a run.
  function automatic bit model_window_end(input int n, input int thr);
    bit v = 1'b0;
    if (win_hist.size() > 0) begin
      int prev;
      int metric;
      prev   = win_hist[$];
      metric = (n > prev) ? (n - prev) : (prev - n);
      if (metric > thr) begin
        streak++;
        v = ((streak % TRIG) == 0);
      end else begin
        streak = 0;
      end
    end
    win_hist.push_back(n);
    return v;
  endfunction

  // Present one bit for the next capture: wait for a pdm_clk rise, then drive data
  task automatic drive_sample(input bit d, input bit exp_v, input bit do_push);
    bit prev = bus.pdm_clk_o;
    bit seen = 1'b0;
    for (int i = 0; i < 4 * PDM_DIV + 4 && !seen; i++) begin
      @(negedge clk);
      if (bus.pdm_clk_o && !prev) seen = 1'b1;
      else prev = bus.pdm_clk_o;
    end
    if (!seen) fatal_timeout("pdm_clk_rise");
    bus.pdm_data_i = d;
    if (do_push) exp_q.push_back(exp_v);
  endtask

  task automatic drive_window(input int n, input bit alt, input int upto, input int thr);
    bit bits[WIN];
    int ones = 0;
    bit v;
    for (int i = 0; i < WIN; i++) bits[i] = alt ? (i % 2 == 0) : (i < n);
    if (!alt) begin
      for (int i = WIN - 1; i > 0; i--) begin
        int j;
        bit t;
        j = int'($urandom_range(i, 0));
        t = bits[i];
        bits[i] = bits[j];
        bits[j] = t;
      end
    end
    for (int i = 0; i < WIN; i++) ones += int'(bits[i]);
    for (int i = 0; i < upto; i++) begin
      v = 1'b0;
      if (i == WIN - 1) v = model_window_end(ones, thr);
      drive_sample(bits[i], v, 1'b1);
      // Previous window's last capture is done by now; safe to change threshold
      if (i == 0) bus.threshold_i = CNT_BW'(thr);
    end
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) fatal_timeout("drain");
    @(negedge clk);
  endtask

  task automatic disarm(input int gap);
    drain();
    bus.en_i = 1'b0;
    win_hist.delete();
    streak = 0;
    @(negedge clk);
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      chk("pdm_clk_low_while_disarmed", int'(bus.pdm_clk_o), 0);
    end
  endtask

  task automatic enable();
    @(negedge clk);
    bus.en_i = 1'b1;
  endtask

  task automatic check_vads(input string name, input int base, input int exp_n);
    drain();
    chk(name, vad_seen - base, exp_n);
  endtask

  // Monitor: every sample_o pops one expectation; vad_o may only appear with sample_o
  initial begin
    forever begin
      @(negedge clk);
      if (mon_on && rst_n) begin
        if (bus.vad_o) vad_seen++;
        if (bus.sample_o) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_sample: sample_o=1 vad_o=%0d with nothing queued (t=%0t)",
                     bus.vad_o, $time);
          end else begin
            bit e;
            e = exp_q.pop_front();
            chk("vad_at_sample", int'(bus.vad_o), int'(e));
          end
        end else if (bus.vad_o) begin
          total++;
          bad++;
          $display("FAIL vad_without_sample: vad_o=1 sample_o=0 expected vad_o=0 (t=%0t)", $time);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int n;
    int thr;
    rst_n          = 1'b0;
    bus.en_i       = 1'b0;
    bus.pdm_data_i = 1'b0;
    bus.threshold_i = CNT_BW'(8);
    repeat (3) @(negedge clk);
    chk("reset_pdm_clk", int'(bus.pdm_clk_o), 0);
    chk("reset_sample", int'(bus.sample_o), 0);
    chk("reset_vad", int'(bus.vad_o), 0);

    // Clock/strobe cadence from reset release with en_i already high
    bus.en_i = 1'b1;
    rst_n    = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("pdm_clk_cadence", int'(bus.pdm_clk_o), ((k + 1) / PDM_DIV) % 2);
      chk("sample_cadence", int'(bus.sample_o), int'(((k + 1) % (2 * PDM_DIV)) == 0));
    end

    // Asynchronous reset mid-cycle while pdm_clk is high
    for (int i = 0; i < 8 && !bus.pdm_clk_o; i++) @(negedge clk);
    if (!bus.pdm_clk_o) fatal_timeout("pdm_clk_high");
    #2 rst_n = 1'b0;
    #1 chk("async_reset_pdm_clk", int'(bus.pdm_clk_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12 && !bus.sample_o; i++) @(negedge clk);
    if (!bus.sample_o) fatal_timeout("sample_high");
    #2 rst_n = 1'b0;
    #1 chk("async_reset_sample", int'(bus.sample_o), 0);
    chk("async_reset_vad", int'(bus.vad_o), 0);
    bus.en_i = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    mon_on = 1'b1;

    // Alternating bits: constant density, never triggers
    base = vad_seen;
    enable();
    for (int w = 0; w < 10; w++) drive_window(8, 1'b1, WIN, 8);
    check_vads("alt_no_vad", base, 0);
    disarm(3);

    // Full/empty windows: pulses after samples 48 and 80
    base = vad_seen;
    enable();
    for (int w = 0; w < 5; w++) drive_window((w % 2 == 0) ? 16 : 0, 1'b0, WIN, 8);
    check_vads("full_empty_vads", base, 2);
    disarm(3);

    // Same activity but metric 16 is not above threshold 16
    base = vad_seen;
    enable();
    for (int w = 0; w < 5; w++) drive_window((w % 2 == 0) ? 16 : 0, 1'b0, WIN, 16);
    check_vads("thr16_no_vad", base, 0);
    disarm(3);

    // Metric 9 vs 8 qualifies; metric 8 vs 8 does not
    base = vad_seen;
    enable();
    drive_window(0, 1'b0, WIN, 8);
    drive_window(9, 1'b0, WIN, 8);
    drive_window(0, 1'b0, WIN, 8);
    check_vads("metric9_hit", base, 1);
    disarm(3);
    base = vad_seen;
    enable();
    drive_window(0, 1'b0, WIN, 8);
    drive_window(8, 1'b0, WIN, 8);
    drive_window(0, 1'b0, WIN, 8);
    check_vads("metric8_miss", base, 0);
    disarm(3);

    // Disarm at sample 40, 10-cycle gap, fresh reference after re-enable
    base = vad_seen;
    enable();
    drive_window(16, 1'b0, WIN, 8);
    drive_window(0, 1'b0, WIN, 8);
    drive_window(16, 1'b0, 8, 8);
    disarm(10);
    chk("no_vad_before_gap", vad_seen - base, 0);
    enable();
    drive_window(16, 1'b0, WIN, 8);
    drive_window(0, 1'b0, WIN, 8);
    drive_window(16, 1'b0, WIN, 8);
    check_vads("reenable_vad", base, 1);
    disarm(3);

    // Hit, miss, hit, hit
    base = vad_seen;
    enable();
    drive_window(0, 1'b0, WIN, 8);
    drive_window(16, 1'b0, WIN, 8);
    drive_window(16, 1'b0, WIN, 8);
    drive_window(0, 1'b0, WIN, 8);
    drive_window(16, 1'b0, WIN, 8);
    check_vads("hit_miss_hit_hit", base, 1);
    disarm(3);

    // Disarm coinciding with a triggering window end: no pulse, no capture
    base = vad_seen;
    enable();
    drive_window(0, 1'b0, WIN, 8);
    drive_window(16, 1'b0, WIN, 8);
    drive_window(0, 1'b0, WIN - 1, 8);
    drive_sample(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus.en_i = 1'b0;
    disarm(4);
    chk("disarm_wins", vad_seen - base, 0);

    // Randomised windows and thresholds
    enable();
    for (int w = 0; w < 30; w++) begin
      n   = ($urandom_range(3, 0) == 0) ? (($urandom_range(1, 0) == 1) ? 16 : 0)
                                        : int'($urandom_range(16, 0));
      thr = ($urandom_range(9, 0) == 0) ? 31 : int'($urandom_range(12, 0));
      drive_window(n, 1'b0, WIN, thr);
    end
    disarm(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
